onehot_decoder_seq: RTL and testbench

- Parametrised, registered binary-to-one-hot decoder. Generalises the 3-to-8 combinational decoder to SEL_W-to-2**SEL_W.
- Adds a valid/ready input handshake and three output modes: HOLD (latched), PULSE (timed one-hot pulse) and SCAN (auto-walking one-hot with wrap).
- Used as the select/strobe generator for banked peripherals, LED or row scanning, and chip-select sequencing.

---
 rtl/onehot_decoder_seq.sv | 87 ++++++++
 tb/tb_onehot_decoder_seq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/onehot_decoder_seq.sv
// onehot_decoder_seq: registered binary-to-one-hot decoder with a valid/ready input and HOLD, PULSE and SCAN output modes
module onehot_decoder_seq #(
    parameter int SEL_W     = 3,
    parameter int PULSE_LEN = 4,
    parameter int SCAN_DIV  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic                  in_valid,
    input  logic [SEL_W-1:0]      in_sel,
    output logic                  in_ready,
    output logic [2**SEL_W-1:0]   out,
    output logic                  out_valid,
    output logic                  busy,
    output logic                  scan_wrap
);
    localparam int OUT_W = 2 ** SEL_W;
    localparam int PW    = $clog2(PULSE_LEN + 1);
    localparam int SW    = $clog2(SCAN_DIV + 1);
    typedef enum logic [1:0] {IDLE, HOLD, PULSE, SCAN} state_t;
    state_t           state_q, state_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic             out_valid_q, busy_q, busy_d, wrap_q, wrap_d;
    logic [PW-1:0]    pcnt_q, pcnt_d;
    logic [SW-1:0]    sdiv_q, sdiv_d;
    logic             accept;
    assign in_ready  = en && mode != 2'b11 && (state_q == IDLE || state_q == HOLD);
    assign accept    = in_valid && in_ready;
    assign busy_d    = state_d == PULSE || state_d == SCAN;
    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign scan_wrap = wrap_q;
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        pcnt_d  = pcnt_q;
        sdiv_d  = sdiv_q;
        wrap_d  = 1'b0;
        if (!en) begin
            state_d = IDLE;
            out_d   = '0;
            pcnt_d  = '0;
            sdiv_d  = '0;
        end else if (accept) begin
            if (mode == 2'b00) state_d = HOLD;
            else if (mode == 2'b01) state_d = PULSE;
            else state_d = SCAN;
            out_d  = OUT_W'(1) << in_sel;
            pcnt_d = PW'(PULSE_LEN - 1);
            sdiv_d = SW'(SCAN_DIV - 1);
        end else if (state_q == PULSE) begin
            if (pcnt_q == '0) begin
                state_d = IDLE;
                out_d   = '0;
            end else pcnt_d = pcnt_q - 1'b1;
        end else if (state_q == SCAN) begin
            // wrap flag marks only the step that rotates the top bit into bit 0
            if (sdiv_q == '0) begin
                out_d  = {out_q[OUT_W-2:0], out_q[OUT_W-1]};
                sdiv_d = SW'(SCAN_DIV - 1);
                wrap_d = out_q[OUT_W-1];
            end else sdiv_d = sdiv_q - 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            wrap_q      <= 1'b0;
            pcnt_q      <= '0;
            sdiv_q      <= '0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            out_valid_q <= |out_d;
            busy_q      <= busy_d;
            wrap_q      <= wrap_d;
            pcnt_q      <= pcnt_d;
            sdiv_q      <= sdiv_d;
        end
    end
endmodule

// File: tb/tb_onehot_decoder_seq.sv
// tb_onehot_decoder_seq: directed and randomized checks of onehot_decoder_seq against a cycle-age reference model
module tb_onehot_decoder_seq;
    localparam int PL = 4;
    logic clk = 1'b0, rst_n = 1'b0;
    logic en = 1'b0, in_valid = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [2:0] in_sel = 3'd0;
    logic in_ready, out_valid, busy, scan_wrap;
    logic [7:0] out;
    logic en1 = 1'b0, v1 = 1'b0;
    logic [1:0] mode1 = 2'b00;
    logic [3:0] sel1 = 4'd0;
    logic rdy1, ov1, busy1, wrap1;
    logic [15:0] out1;
    int tests = 0, fails = 0;
    int m_kind = 0, m_sel = 0, m_age = 0; // kind: 0 idle, 1 hold, 2 pulse, 3 scan
    logic exp_rdy, got_rdy;

    onehot_decoder_seq #(.SEL_W(3), .PULSE_LEN(PL), .SCAN_DIV(1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid), .in_sel(in_sel),
        .in_ready(in_ready), .out(out), .out_valid(out_valid), .busy(busy), .scan_wrap(scan_wrap));
    onehot_decoder_seq #(.SEL_W(4), .PULSE_LEN(1), .SCAN_DIV(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en1), .mode(mode1), .in_valid(v1), .in_sel(sel1),
        .in_ready(rdy1), .out(out1), .out_valid(ov1), .busy(busy1), .scan_wrap(wrap1));

    always #5 clk = ~clk;

    function automatic logic [7:0] m_out();
        if (m_kind == 0) return 8'h00;
        if (m_kind == 3) return 8'h01 << ((m_sel + m_age) % 8);
        return 8'h01 << m_sel;
    endfunction
    function automatic logic m_wrap();
        return m_kind == 3 && m_age > 0 && (m_sel + m_age) % 8 == 0;
    endfunction

    task automatic step(input logic e, input logic [1:0] md, input logic v, input logic [2:0] s);
        @(negedge clk);
        en = e; mode = md; in_valid = v; in_sel = s;
        #1;
        got_rdy = in_ready;
        exp_rdy = e && md != 2'b11 && m_kind <= 1;
        @(posedge clk);
        if (!e) m_kind = 0;
        else if (v && exp_rdy) begin
            m_kind = int'(md) + 1;
            m_sel  = int'(s);
            m_age  = 0;
        end else if (m_kind >= 2) begin
            m_age++;
            if (m_kind == 2 && m_age == PL) m_kind = 0;
        end
        #1;
    endtask

    task automatic step1(input logic e, input logic [1:0] md, input logic v, input logic [3:0] s);
        @(negedge clk);
        en1 = e; mode1 = md; v1 = v; sel1 = s;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests++; if (out !== 8'h00 || out_valid !== 1'b0) begin fails++; $display("FAIL reset_out got %h/%b exp 00/0", out, out_valid); end
        tests++; if (busy !== 1'b0 || scan_wrap !== 1'b0 || in_ready !== 1'b0) begin fails++; $display("FAIL reset_flags got %b%b%b exp 000", busy, scan_wrap, in_ready); end
        rst_n = 1'b1;
        step(1'b0, 2'b00, 1'b0, 3'd0);
        tests++; if (out !== 8'h00) begin fails++; $display("FAIL reset_release got %h exp 00", out); end
        step(1'b1, 2'b00, 1'b0, 3'd2);
        tests++; if (out !== 8'h00 || got_rdy !== 1'b1) begin fails++; $display("FAIL no_valid got %h rdy %b exp 00 rdy 1", out, got_rdy); end
    endtask

    task automatic test_hold();
        step(1'b1, 2'b00, 1'b1, 3'd5);
        tests++; if (out !== 8'h20 || out_valid !== 1'b1) begin fails++; $display("FAIL hold_first got %h/%b exp 20/1", out, out_valid); end
        step(1'b1, 2'b00, 1'b1, 3'd1);
        tests++; if (out !== 8'h02 || busy !== 1'b0) begin fails++; $display("FAIL hold_replace got %h busy %b exp 02 busy 0", out, busy); end
        step(1'b1, 2'b00, 1'b0, 3'd6);
        tests++; if (out !== 8'h02) begin fails++; $display("FAIL hold_keep got %h exp 02", out); end
    endtask

    task automatic test_pulse();
        step(1'b1, 2'b01, 1'b1, 3'd2);
        for (int i = 0; i < PL; i++) begin
            tests++; if (out !== 8'h04 || busy !== 1'b1) begin fails++; $display("FAIL pulse_on[%0d] got %h busy %b exp 04 busy 1", i, out, busy); end
            step(1'b1, 2'b00, 1'b1, 3'd3);
            tests++; if (got_rdy !== 1'b0) begin fails++; $display("FAIL pulse_rdy[%0d] got %b exp 0", i, got_rdy); end
        end
        tests++; if (out !== 8'h00 || busy !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL pulse_end got %h/%b/%b exp 00/0/0", out, busy, out_valid); end
        step(1'b1, 2'b00, 1'b0, 3'd0);
        tests++; if (got_rdy !== 1'b1) begin fails++; $display("FAIL pulse_rdy_back got %b exp 1", got_rdy); end
    endtask

    task automatic test_scan();
        logic [7:0] exp_s [4] = '{8'h40, 8'h80, 8'h01, 8'h02};
        step(1'b1, 2'b10, 1'b1, 3'd6);
        for (int i = 0; i < 4; i++) begin
            tests++; if (out !== exp_s[i] || scan_wrap !== (i == 2) || busy !== 1'b1) begin fails++; $display("FAIL scan[%0d] got %h wrap %b busy %b exp %h wrap %b busy 1", i, out, scan_wrap, busy, exp_s[i], i == 2); end
            step(1'b1, 2'b00, 1'b1, 3'd0);
            tests++; if (got_rdy !== 1'b0) begin fails++; $display("FAIL scan_rdy[%0d] got %b exp 0", i, got_rdy); end
        end
    endtask

    task automatic test_en_drop();
        step(1'b0, 2'b00, 1'b0, 3'd0);
        step(1'b1, 2'b01, 1'b1, 3'd3);
        step(1'b1, 2'b01, 1'b0, 3'd0);
        step(1'b0, 2'b00, 1'b1, 3'd4);
        tests++; if (out !== 8'h00 || busy !== 1'b0 || got_rdy !== 1'b0) begin fails++; $display("FAIL en_drop_pulse got %h busy %b rdy %b exp 00 0 0", out, busy, got_rdy); end
        step(1'b0, 2'b00, 1'b1, 3'd4);
        tests++; if (out !== 8'h00) begin fails++; $display("FAIL en_low_valid got %h exp 00", out); end
        step(1'b1, 2'b10, 1'b1, 3'd0);
        tests++; if (out !== 8'h01 || scan_wrap !== 1'b0) begin fails++; $display("FAIL scan_load0 got %h wrap %b exp 01 wrap 0", out, scan_wrap); end
        step(1'b1, 2'b00, 1'b0, 3'd0);
        tests++; if (out !== 8'h02) begin fails++; $display("FAIL scan_step got %h exp 02", out); end
        step(1'b0, 2'b00, 1'b1, 3'd0);
        tests++; if (out !== 8'h00 || busy !== 1'b0 || scan_wrap !== 1'b0) begin fails++; $display("FAIL en_drop_scan got %h %b %b exp 00 0 0", out, busy, scan_wrap); end
    endtask

    task automatic test_async_reset();
        step(1'b1, 2'b01, 1'b1, 3'd7);
        tests++; if (out !== 8'h80) begin fails++; $display("FAIL areset_pre got %h exp 80", out); end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests++; if (out !== 8'h00 || busy !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL areset_now got %h %b %b exp 00 0 0", out, busy, out_valid); end
        m_kind = 0;
        en = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 2'b00, 1'b1, 3'd4);
        tests++; if (out !== 8'h10 || out_valid !== 1'b1) begin fails++; $display("FAIL areset_after got %h/%b exp 10/1", out, out_valid); end
    endtask

    task automatic test_reserved();
        step(1'b1, 2'b00, 1'b1, 3'd3);
        step(1'b1, 2'b11, 1'b1, 3'd6);
        tests++; if (got_rdy !== 1'b0 || out !== 8'h08) begin fails++; $display("FAIL reserved got rdy %b out %h exp 0 08", got_rdy, out); end
    endtask

    task automatic test_random();
        logic [7:0] e_out;
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 15) != 0, 2'($urandom_range(0, 3)), $urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)));
            e_out = m_out();
            tests++; if (got_rdy !== exp_rdy) begin fails++; $display("FAIL rnd_rdy[%0d] got %b exp %b", n, got_rdy, exp_rdy); end
            tests++; if (out !== e_out || out_valid !== (e_out != 0)) begin fails++; $display("FAIL rnd_out[%0d] got %h/%b exp %h/%b", n, out, out_valid, e_out, e_out != 0); end
            tests++; if (busy !== (m_kind >= 2) || scan_wrap !== m_wrap()) begin fails++; $display("FAIL rnd_flags[%0d] got busy %b wrap %b exp %b %b", n, busy, scan_wrap, m_kind >= 2, m_wrap()); end
            tests++; if (!$onehot0(out)) begin fails++; $display("FAIL rnd_onehot[%0d] got %h exp onehot0", n, out); end
        end
        step(1'b0, 2'b00, 1'b0, 3'd0);
    endtask

    task automatic test_wide();
        logic [15:0] e1;
        step1(1'b1, 2'b00, 1'b1, 4'd15);
        tests++; if (out1 !== 16'h8000 || ov1 !== 1'b1) begin fails++; $display("FAIL wide_hold got %h/%b exp 8000/1", out1, ov1); end
        step1(1'b1, 2'b01, 1'b1, 4'd3);
        tests++; if (out1 !== 16'h0008 || busy1 !== 1'b1) begin fails++; $display("FAIL wide_strobe got %h busy %b exp 0008 1", out1, busy1); end
        step1(1'b1, 2'b00, 1'b0, 4'd0);
        tests++; if (out1 !== 16'h0000 || busy1 !== 1'b0 || rdy1 !== 1'b1) begin fails++; $display("FAIL wide_strobe_end got %h %b rdy %b exp 0000 0 1", out1, busy1, rdy1); end
        step1(1'b1, 2'b10, 1'b1, 4'd14);
        for (int i = 0; i < 9; i++) begin
            e1 = 16'h0001 << ((14 + i / 3) % 16);
            tests++; if (out1 !== e1 || wrap1 !== (i == 6)) begin fails++; $display("FAIL wide_scan[%0d] got %h wrap %b exp %h wrap %b", i, out1, wrap1, e1, i == 6); end
            step1(1'b1, 2'b00, 1'b1, 4'd0);
        end
        step1(1'b0, 2'b00, 1'b0, 4'd0);
        tests++; if (out1 !== 16'h0000 || busy1 !== 1'b0) begin fails++; $display("FAIL wide_clear got %h %b exp 0000 0", out1, busy1); end
    endtask

    initial begin
        test_reset();
        test_hold();
        test_pulse();
        test_scan();
        test_en_drop();
        test_async_reset();
        test_reserved();
        test_random();
        test_wide();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
